// File: rtl/gfx_fade_engine.sv
// gfx_fade_engine: ages live visible pixels of the read stream and queues write-backs; GFX_FADE_STATS_EN adds drop_count
module gfx_fade_engine #(
  parameter int PIXEL_BITS     = 12,
  parameter int AGE_BITS       = 4,
  parameter int ADDR_WIDTH     = 20,
  parameter int FIFO_ADDR_SIZE = 3,
  parameter int FRAME_DIV_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_mode,
  input  logic [AGE_BITS-1:0]            cfg_shift_age,
  input  logic [FRAME_DIV_BITS-1:0]      cfg_frame_div,
  input  logic                           vsync,
  input  logic                           in_valid,
  input  logic                           in_visible,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  input  logic [AGE_BITS+PIXEL_BITS-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic [AGE_BITS+PIXEL_BITS-1:0] out_data,
  output logic                           age_frame
`ifdef GFX_FADE_STATS_EN
  ,
  output logic [15:0]                    drop_count
`endif
);
  localparam int COLOR_BITS = PIXEL_BITS / 3;
  localparam int DW         = AGE_BITS + PIXEL_BITS;
  localparam int DEPTH      = 1 << FIFO_ADDR_SIZE;

  logic                      vsync_d;
  logic [FRAME_DIV_BITS-1:0] frame_cnt;
  logic                      s1_valid, s2_valid;
  logic [ADDR_WIDTH-1:0]     s1_addr, s2_addr;
  logic [DW-1:0]             s1_data, s2_data;
  logic [AGE_BITS-1:0]       next_age;
  logic [PIXEL_BITS-1:0]     next_color;
  logic [ADDR_WIDTH-1:0]     mem_addr [DEPTH];
  logic [DW-1:0]             mem_data [DEPTH];
  logic [FIFO_ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_SIZE:0]   count;
  logic                      full, pop, push, drop;

  // Frame divider: every (cfg_frame_div+1)-th vsync rise opens an aging frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vsync_d   <= 1'b0;
      frame_cnt <= '0;
      age_frame <= 1'b0;
    end else begin
      vsync_d <= vsync;
      if (vsync && !vsync_d) begin
        frame_cnt <= (frame_cnt >= cfg_frame_div) ? '0 : frame_cnt + 1'b1;
        age_frame <= frame_cnt >= cfg_frame_div;
      end
    end

  // Two-stage candidate pipeline; stage 2 feeds the aging math and the FIFO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_addr  <= '0;
      s2_addr  <= '0;
      s1_data  <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= in_valid && in_visible && (in_data[DW-1 -: AGE_BITS] != '0) && age_frame;
      s1_addr  <= in_addr;
      s1_data  <= in_data;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= s1_data;
    end

  assign next_age = s2_data[DW-1 -: AGE_BITS] - 1'b1;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [COLOR_BITS-1:0] ch;
    assign ch = s2_data[c*COLOR_BITS +: COLOR_BITS];
    assign next_color[c*COLOR_BITS +: COLOR_BITS] =
      (next_age == '0) ? '0 :
      cfg_mode         ? ((ch == '0) ? '0 : ch - 1'b1) :
      (next_age == cfg_shift_age) ? (ch >> 1) : ch;
  end
  if (PIXEL_BITS > 3*COLOR_BITS) begin : g_pad
    assign next_color[PIXEL_BITS-1:3*COLOR_BITS] = '0;
  end

  // A full FIFO still takes a write when the head leaves in the same cycle
  assign full      = count[FIFO_ADDR_SIZE];
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign push      = s2_valid && (!full || pop);
  assign drop      = s2_valid && full && !pop;
  assign out_addr  = out_valid ? mem_addr[rd_ptr] : '0;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;

  // FIFO storage needs no reset; reads are gated by out_valid
  always_ff @(posedge clk)
    if (push) begin
      mem_addr[wr_ptr] <= s2_addr;
      mem_data[wr_ptr] <= {next_age, next_color};
    end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{(FIFO_ADDR_SIZE-1){1'b0}}, push};
      rd_ptr <= rd_ptr + {{(FIFO_ADDR_SIZE-1){1'b0}}, pop};
      count  <= count + {{FIFO_ADDR_SIZE{1'b0}}, push} - {{FIFO_ADDR_SIZE{1'b0}}, pop};
    end

`ifdef GFX_FADE_STATS_EN
  // Saturating count of write-backs lost to a full FIFO
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule
